// File: rtl/pic24_pkg.sv
// Shared types and widths for the PIC24 fetch path: state encoding,
// bus widths and the queued instruction record.
package pic24_pkg;

    localparam int INSTR_W = 24;
    localparam int PADDR_W = 24;
    localparam int MEM_W   = 16;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_RD_LO  = 3'd1,
        FS_RD_HI  = 3'd2,
        FS_INC    = 3'd3,
        FS_SETTLE = 3'd4,
        FS_DROP   = 3'd5
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PADDR_W-1:0] addr;
    } fetch_entry_t;

    // A 24-bit instruction is the upper byte lane on top of the low word.
    function automatic logic [INSTR_W-1:0] join_instr(input logic [7:0] hi_byte,
                                                      input logic [MEM_W-1:0] lo_word);
        return {hi_byte, lo_word};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory read bus plus the decode-side valid/ready handshake.
// master = fetch stage, slave = memory/decode environment.
interface instr_fetch_if;
    import pic24_pkg::*;

    logic               mem_rd_o;
    logic [PADDR_W-1:0] mem_addr_o;
    logic               mem_hi_o;
    logic [MEM_W-1:0]   mem_rdata_i;
    logic               mem_ack_i;
    logic [INSTR_W-1:0] instr_o;
    logic [PADDR_W-1:0] instr_addr_o;
    logic               instr_valid_o;
    logic               instr_ready_i;

    modport master (
        output mem_rd_o, mem_addr_o, mem_hi_o,
        output instr_o, instr_addr_o, instr_valid_o,
        input  mem_rdata_i, mem_ack_i, instr_ready_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o, mem_hi_o,
        input  instr_o, instr_addr_o, instr_valid_o,
        output mem_rdata_i, mem_ack_i, instr_ready_i
    );

endinterface

// File: rtl/instr_queue.sv
// Small FIFO of fetched instructions with their addresses. Flush wins over
// push and pop; the head is forced to zero while the queue is empty.
module instr_queue
    import pic24_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     entry_vec [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !flush_i;
    assign pop_ok  = pop_i && !flush_i && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data_i;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    // Pointers are PTR_W wide, so increments wrap modulo DEPTH for free.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign valid_o = (count_reg != '0);
    assign head_o  = valid_o ? entry_vec[rd_ptr_reg] : '0;
    assign count_o = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// PIC24 instruction fetch: two bus reads per instruction (low word, upper
// byte), PC increment pulse, and a small queue towards decode.
module instr_fetch
    import pic24_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fetch_en_i,
    input  logic               flush_i,
    input  logic [PADDR_W-1:0] pc_addr_i,
    output logic               pcinc_o,
    instr_fetch_if.master      bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [2:0] ST_IDLE   = FS_IDLE;
    localparam logic [2:0] ST_RD_LO  = FS_RD_LO;
    localparam logic [2:0] ST_RD_HI  = FS_RD_HI;
    localparam logic [2:0] ST_INC    = FS_INC;
    localparam logic [2:0] ST_SETTLE = FS_SETTLE;
    localparam logic [2:0] ST_DROP   = FS_DROP;

    logic [2:0]         state_reg, state_next;
    logic [PADDR_W-1:0] addr_reg, addr_next;
    logic [MEM_W-1:0]   lo_reg, lo_next;
    logic               drop_hi_reg, drop_hi_next;

    logic [CNT_W-1:0]   q_count;
    logic               q_valid;
    fetch_entry_t       q_head;
    fetch_entry_t       push_entry;
    logic               push;
    logic               pop;
    logic               start_ok;
    logic               unused_rdata_hi;

    assign start_ok = fetch_en_i && (q_count < DEPTH_C);

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        lo_next      = lo_reg;
        drop_hi_next = drop_hi_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!flush_i && start_ok) begin
                    addr_next  = pc_addr_i;
                    state_next = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                if (flush_i) begin
                    state_next   = bus.mem_ack_i ? ST_IDLE : ST_DROP;
                    drop_hi_next = 1'b0;
                end else if (bus.mem_ack_i) begin
                    lo_next    = bus.mem_rdata_i;
                    state_next = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (flush_i) begin
                    state_next   = bus.mem_ack_i ? ST_IDLE : ST_DROP;
                    drop_hi_next = 1'b1;
                end else if (bus.mem_ack_i) begin
                    state_next = ST_INC;
                end
            end
            ST_INC: begin
                state_next = flush_i ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!flush_i && start_ok) begin
                    addr_next  = pc_addr_i;
                    state_next = ST_RD_LO;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                // The abandoned read must still complete on the bus.
                if (bus.mem_ack_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            lo_reg      <= '0;
            drop_hi_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            lo_reg      <= lo_next;
            drop_hi_reg <= drop_hi_next;
        end
    end

    assign pcinc_o        = (state_reg == ST_INC);
    assign bus.mem_rd_o   = (state_reg == ST_RD_LO) || (state_reg == ST_RD_HI) ||
                            (state_reg == ST_DROP);
    assign bus.mem_hi_o   = (state_reg == ST_RD_HI) ||
                            ((state_reg == ST_DROP) && drop_hi_reg);
    assign bus.mem_addr_o = addr_reg;

    assign push            = (state_reg == ST_RD_HI) && bus.mem_ack_i && !flush_i;
    assign push_entry      = '{instr: join_instr(bus.mem_rdata_i[7:0], lo_reg),
                               addr:  addr_reg};
    assign pop             = q_valid && bus.instr_ready_i;
    assign unused_rdata_hi = ^bus.mem_rdata_i[15:8];

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    assign bus.instr_o       = q_head.instr;
    assign bus.instr_addr_o  = q_head.addr;
    assign bus.instr_valid_o = q_valid;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the PIC24 core, directly downstream of `program_counter`. It reads the 24-bit instruction at the current PC from program memory as two 16-bit bus reads: the low word, then the upper byte. It pulses the PC increment and buffers fetched instructions with their addresses in a small queue, which feeds decode over a valid/ready handshake. The control sequencer stops and flushes it around PC reloads.

## Interface
- `DEPTH`, default 2: instruction queue entries; power of two, ≥2.
- `clk_i  in  1`: clock; all logic on rising edge.
- `rst_i  in  1`: synchronous, active-high reset.
- `fetch_en_i  in  1`: permits starting new fetches.
- `flush_i  in  1`: discard queue and any in-flight fetch (branch/PC reload).
- `pc_addr_i  in  24`: PC from `program_counter`; bit 0 always 0.
- `pcinc_o  out  1`: one-cycle increment pulse to `program_counter`.
- `mem_rd_o  out  1`: program memory read request.
- `mem_addr_o  out  24`: read address (the sampled PC).
- `mem_hi_o  out  1`: 0 = low word lane; 1 = upper byte lane.
- `mem_rdata_i  in  16`: read data, valid when `mem_ack_i`=1.
- `mem_ack_i  in  1`: read complete; may be asserted in the same cycle as the request.
- `instr_o  out  24`: head-of-queue instruction `{hi[7:0], lo[15:0]}`.
- `instr_addr_o  out  24`: address of `instr_o`.
- `instr_valid_o  out  1`: queue non-empty.
- `instr_ready_i  in  1`: decode accepts the head entry when valid&&ready.

## Operation
- FSM states: IDLE, RD_LO, RD_HI, INC, SETTLE, DROP.
- IDLE: if `fetch_en_i` && count<DEPTH, latch `pc_addr_i` into the address register and go to RD_LO.
- RD_LO: `mem_rd_o`=1, `mem_hi_o`=0, address from register. On `mem_ack_i`, capture `mem_rdata_i` as lo and go to RD_HI.
- RD_HI: `mem_rd_o`=1, `mem_hi_o`=1, same address. On `mem_ack_i`, push `{mem_rdata_i[7:0], lo}` plus address into the queue, then go to INC. `mem_rdata_i[15:8]` is ignored.
- INC: `pcinc_o`=1 for exactly this cycle, then go to SETTLE.
- SETTLE: one wait cycle while the PC updates. Then go to RD_LO (re-latching `pc_addr_i`) if `fetch_en_i` && count<DEPTH, else IDLE.
- Only one fetch is in flight at a time. A fetch starts only when count<DEPTH, so a push never meets a full queue.
- Deasserting `fetch_en_i` mid-fetch does not abort; the current fetch completes through SETTLE, then the FSM idles.
- Queue: push in RD_HI on ack; pop on valid&&ready. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Flush (priority over push and pop):
  - Queue is emptied; `instr_valid_o`=0 from the next cycle.
  - In IDLE, INC or SETTLE: go to IDLE. `pcinc_o` is still driven if flush lands in INC.
  - In RD_LO or RD_HI with `mem_ack_i`=1 that cycle: data discarded, go to IDLE.
  - In RD_LO or RD_HI without ack: go to DROP.
  - DROP: keep `mem_rd_o`=1 with the address stable until `mem_ack_i`, discard the data, then go to IDLE. Another `flush_i` in DROP has no extra effect.
- Reset: state IDLE, queue empty. All outputs 0: `pcinc_o`, `mem_rd_o`, `mem_addr_o`, `mem_hi_o`, `instr_o`, `instr_addr_o`, `instr_valid_o`. Reset mid-fetch abandons the bus request immediately.

## Timing
- Memory handshake: `mem_rd_o`, `mem_addr_o` and `mem_hi_o` are held stable until the cycle of `mem_ack_i`, inclusive. Zero wait states are allowed.
- Zero-wait memory, empty queue, fetch from IDLE at cycle 0:
  - RD_LO at cycle 1, RD_HI at cycle 2.
  - `instr_valid_o`=1 at cycle 3, with `pcinc_o`=1 in the same cycle.
  - SETTLE at cycle 4; next RD_LO at cycle 5.
- Steady-state throughput: 4 cycles per instruction plus memory wait states.
- `pc_addr_i` is sampled on entry to RD_LO, at least 2 cycles after `pcinc_o`. It must then be stable; the sequencer guarantees this.
- Queue output is registered-state driven; there is no combinational path from `instr_ready_i` to `instr_valid_o`.

## Structure
- `pic24_pkg` holds:
  - `fetch_state_e` (the six states).
  - `INSTR_W`=24 and `PADDR_W`=24.
  - A packed struct `fetch_entry_t` {instr, addr}.
- Sub-module `instr_queue`: parameterised DEPTH FIFO of `fetch_entry_t` with push/pop/flush, count, valid. `instr_fetch` instantiates one.

## Test plan
- Reset, then `fetch_en_i`=1, PC=0x000000, zero-wait memory returning lo=0xA55A and hi=0x??3C:
  - `instr_o`=0x3CA55A and `instr_addr_o`=0x000000 valid at cycle 3.
  - Exactly one `pcinc_o` pulse.
- `instr_ready_i`=0 with PC advancing 0→2→4:
  - Exactly 2 entries are fetched (0x000000, 0x000002).
  - No third `mem_rd_o` until a pop.
  - A pop restarts the fetch at 0x000004.
- Memory with 3 wait states per read:
  - Address and `mem_hi_o` are stable across the waits.
  - Throughput is 10 cycles per instruction.
- `flush_i` in RD_HI with ack delayed 2 cycles:
  - DROP holds `mem_rd_o` until ack.
  - No push occurs; queue is empty; `pcinc_o` is not pulsed.
  - FSM returns to IDLE.
- `flush_i` and a pop in the same cycle with 2 entries queued: count becomes 0 and `instr_valid_o`=0 next cycle.
- `rst_i` asserted during RD_LO: all outputs 0 next cycle; fetch restarts from the new `pc_addr_i` after release.
